if_stage_ctrl: RTL and testbench

- Fetch-side consumer of the hazard unit's control outputs: PC-write enable, IF/ID-write enable and flush.
- Owns the PC register, PC next-address mux, IF/ID pipeline latch and a RUN/HALTED state machine.
- Sits between instruction memory (combinational read at o_pc) and the ID stage.
- Also gated by the debug unit's step/run enable.

---
 rtl/if_stage_ctrl_pkg.sv | 17 +
 rtl/ifid_latch.sv | 38 +++
 rtl/if_stage_ctrl.sv | 131 +++++++++++++
 tb/tb_if_stage_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_ctrl_pkg.sv
// Shared encodings for the fetch stage: PC-source select, fetch FSM states
// and the default bubble instruction.
package if_stage_ctrl_pkg;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_J   = 2'b10;
   localparam logic [1:0] PC_SRC_JR  = 2'b11;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

endpackage

// File: rtl/ifid_latch.sv
// Generic pipeline latch: {pc4, instruction, valid} with write enable and a
// bubble-load input that replaces the contents with a NOP.
module ifid_latch #(
   parameter int          BITS_PC   = 32,
   parameter int          BITS_INST = 32,
   parameter logic [BITS_INST-1:0] NOP_INST = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 write_en,
   input  logic                 bubble,
   input  logic [BITS_PC-1:0]   pc4_d,
   input  logic [BITS_INST-1:0] inst_d,
   output logic [BITS_PC-1:0]   pc4,
   output logic [BITS_INST-1:0] inst,
   output logic                 valid
);

   // A bubble carries no meaningful PC, so pc4 is cleared like at reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc4   <= '0;
         inst  <= NOP_INST;
         valid <= 1'b0;
      end else if (write_en) begin
         if (bubble) begin
            pc4   <= '0;
            inst  <= NOP_INST;
            valid <= 1'b0;
         end else begin
            pc4   <= pc4_d;
            inst  <= inst_d;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch stage control: PC register, next-PC mux, IF/ID latch and RUN/HALTED FSM.
// Optional stall-cycle counter is built when IF_STALL_CNT_EN is defined.
module if_stage_ctrl
   import if_stage_ctrl_pkg::*;
#(
   parameter int                   BITS_PC   = 32,
   parameter int                   BITS_INST = 32,
   parameter logic [BITS_PC-1:0]   PC_RESET  = '0,
   parameter logic [BITS_INST-1:0] NOP_INST  = BITS_INST'(NOP_INST_DEFAULT)
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_enable,
   input  logic                 i_pc_write,
   input  logic                 i_IFID_write,
   input  logic                 i_flush_latch,
   input  logic                 i_halt,
   input  logic [1:0]           i_pc_src,
   input  logic [BITS_PC-1:0]   i_branch_target,
   input  logic [BITS_PC-1:0]   i_jump_target,
   input  logic [BITS_PC-1:0]   i_reg_target,
   input  logic [BITS_INST-1:0] i_instruction,
   output logic [BITS_PC-1:0]   o_pc,
   output logic [BITS_PC-1:0]   o_IFID_pc4,
   output logic [BITS_INST-1:0] o_IFID_instruction,
   output logic                 o_IFID_valid,
   output logic                 o_halted,
   output logic [15:0]          o_stall_count
);

   state_t               state, state_next;
   logic [BITS_PC-1:0]   pc, pc_next, pc_plus4;
   logic                 pc_we, latch_we, latch_bubble, stall;

   assign pc_plus4 = pc + BITS_PC'(4);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_RUN;
         pc    <= PC_RESET;
      end else if (i_enable) begin
         state <= state_next;
         if (pc_we) pc <= pc_next;
      end
   end

   // Flush beats everything, including a halt and a hazard stall.
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      pc_we        = 1'b0;
      latch_we     = 1'b0;
      latch_bubble = 1'b0;
      stall        = 1'b0;
      case (state)
         ST_RUN: begin
            if (i_flush_latch) begin
               pc_we        = 1'b1;
               pc_next      = i_branch_target;
               latch_we     = 1'b1;
               latch_bubble = 1'b1;
            end else if (!i_pc_write && !i_IFID_write) begin
               stall = 1'b1;
            end else if (i_halt) begin
               latch_we     = 1'b1;
               latch_bubble = 1'b1;
               state_next   = ST_HALTED;
            end else begin
               pc_we    = i_pc_write;
               latch_we = i_IFID_write;
               if (i_pc_src == PC_SRC_J) begin
                  pc_next      = i_jump_target;
                  latch_bubble = 1'b1;
               end else if (i_pc_src == PC_SRC_JR) begin
                  pc_next      = i_reg_target;
                  latch_bubble = 1'b1;
               end else begin
                  pc_next = pc_plus4;
               end
            end
         end
         ST_HALTED: begin
            latch_we     = 1'b1;
            latch_bubble = 1'b1;
            if (i_flush_latch) begin
               pc_we      = 1'b1;
               pc_next    = i_branch_target;
               state_next = ST_RUN;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   ifid_latch #(
      .BITS_PC   (BITS_PC),
      .BITS_INST (BITS_INST),
      .NOP_INST  (NOP_INST)
   ) u_ifid (
      .clk      (i_clk),
      .reset_n  (i_reset_n),
      .write_en (i_enable && latch_we),
      .bubble   (latch_bubble),
      .pc4_d    (pc_plus4),
      .inst_d   (i_instruction),
      .pc4      (o_IFID_pc4),
      .inst     (o_IFID_instruction),
      .valid    (o_IFID_valid)
   );

   assign o_pc     = pc;
   assign o_halted = (state == ST_HALTED);

`ifdef IF_STALL_CNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         stall_cnt <= '0;
      else if (i_enable && stall && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign o_stall_count = stall_cnt;
`else
   logic unused_stall;
   assign unused_stall  = stall;
   assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: sequential fetch, stalls, flush, redirect,
// halt, enable gating, async reset and PC wrap.
module tb_if_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable, pc_write, ifid_write, flush, halt;
   logic [1:0]  pc_src;
   logic [31:0] br_tgt, j_tgt, r_tgt, instr;
   logic [31:0] pc, pc4, inst;
   logic        valid, halted;
   logic [15:0] stall_cnt;

   int n_vec = 0;
   int n_err = 0;

`ifdef IF_STALL_CNT_EN
   localparam logic [15:0] EXP_STALLS = 16'd2;
`else
   localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign instr = imem(pc);

   if_stage_ctrl dut (
      .i_clk              (clk),
      .i_reset_n          (rst_n),
      .i_enable           (enable),
      .i_pc_write         (pc_write),
      .i_IFID_write       (ifid_write),
      .i_flush_latch      (flush),
      .i_halt             (halt),
      .i_pc_src           (pc_src),
      .i_branch_target    (br_tgt),
      .i_jump_target      (j_tgt),
      .i_reg_target       (r_tgt),
      .i_instruction      (instr),
      .o_pc               (pc),
      .o_IFID_pc4         (pc4),
      .o_IFID_instruction (inst),
      .o_IFID_valid       (valid),
      .o_halted           (halted),
      .o_stall_count      (stall_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pc(input string name, input logic [31:0] exp);
      n_vec++;
      if (pc !== exp) begin
         n_err++;
         $display("FAIL %s: o_pc got %h want %h", name, pc, exp);
      end
   endtask

   task automatic chk_latch(input string name, input logic [31:0] e_pc4,
                            input logic [31:0] e_inst, input logic e_valid);
      n_vec++;
      if (pc4 !== e_pc4 || inst !== e_inst || valid !== e_valid) begin
         n_err++;
         $display("FAIL %s: latch got {%h,%h,%b} want {%h,%h,%b}",
                  name, pc4, inst, valid, e_pc4, e_inst, e_valid);
      end
   endtask

   task automatic chk_bubble(input string name);
      n_vec++;
      if (inst !== 32'h0 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s: bubble got inst=%h valid=%b want inst=0 valid=0",
                  name, inst, valid);
      end
   endtask

   task automatic chk_halted(input string name, input logic exp);
      n_vec++;
      if (halted !== exp) begin
         n_err++;
         $display("FAIL %s: o_halted got %b want %b", name, halted, exp);
      end
   endtask

   task automatic chk_cnt(input string name, input logic [15:0] exp);
      n_vec++;
      if (stall_cnt !== exp) begin
         n_err++;
         $display("FAIL %s: o_stall_count got %0d want %0d", name, stall_cnt, exp);
      end
   endtask

   task automatic idle_inputs();
      enable = 1'b1; pc_write = 1'b1; ifid_write = 1'b1;
      flush = 1'b0; halt = 1'b0; pc_src = 2'b00;
      br_tgt = '0; j_tgt = '0; r_tgt = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #12;
      chk_pc("reset_pc", 32'h0);
      chk_latch("reset_latch", 32'h0, 32'h0, 1'b0);
      chk_halted("reset_halted", 1'b0);
      chk_cnt("reset_cnt", 16'd0);
      rst_n = 1'b1;
   endtask

   task automatic test_seq();
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_pc("seq_pc", 32'(4 * k));
         chk_latch("seq_latch", 32'(4 * k), imem(32'(4 * (k - 1))), 1'b1);
      end
   endtask

   task automatic test_stall();
      pc_write = 1'b0; ifid_write = 1'b0;
      step(); step();
      chk_pc("stall_pc", 32'd16);
      chk_latch("stall_latch", 32'd16, imem(32'd12), 1'b1);
      chk_cnt("stall_cnt", EXP_STALLS);
      pc_write = 1'b1; ifid_write = 1'b1;
      step();
      chk_pc("stall_release_pc", 32'd20);
      chk_latch("stall_release_latch", 32'd20, imem(32'd16), 1'b1);
      pc_write = 1'b0;
      step();
      chk_pc("pcw0_pc", 32'd20);
      chk_latch("pcw0_latch", 32'd24, imem(32'd20), 1'b1);
      pc_write = 1'b1; ifid_write = 1'b0;
      step();
      chk_pc("ifidw0_pc", 32'd24);
      chk_latch("ifidw0_latch", 32'd24, imem(32'd20), 1'b1);
      ifid_write = 1'b1;
   endtask

   task automatic test_flush();
      flush = 1'b1; br_tgt = 32'h40; pc_write = 1'b0; halt = 1'b1;
      step();
      chk_pc("flush_pc", 32'h40);
      chk_bubble("flush_bubble");
      chk_halted("flush_beats_halt", 1'b0);
      chk_cnt("flush_not_stall", EXP_STALLS);
      idle_inputs();
   endtask

   task automatic test_redirect();
      pc_src = 2'b10; j_tgt = 32'h100;
      step();
      chk_pc("jump_pc", 32'h100);
      chk_bubble("jump_bubble");
      pc_src = 2'b11; r_tgt = 32'h200;
      step();
      chk_pc("jr_pc", 32'h200);
      chk_bubble("jr_bubble");
      pc_src = 2'b01; br_tgt = 32'h40;
      step();
      chk_pc("br_noflush_pc", 32'h204);
      chk_latch("br_noflush_latch", 32'h204, imem(32'h200), 1'b1);
      pc_src = 2'b00;
   endtask

   task automatic test_halt();
      halt = 1'b1;
      step();
      chk_pc("halt_pc", 32'h204);
      chk_halted("halt_set", 1'b1);
      chk_bubble("halt_bubble");
      halt = 1'b0; pc_src = 2'b10; j_tgt = 32'h500;
      pc_write = 1'b0; ifid_write = 1'b0;
      step();
      chk_pc("halted_ignores_pc", 32'h204);
      chk_halted("halted_holds", 1'b1);
      chk_bubble("halted_bubble");
      chk_cnt("halted_no_stall_cnt", EXP_STALLS);
      idle_inputs();
      flush = 1'b1; br_tgt = 32'h80;
      step();
      chk_pc("unhalt_pc", 32'h80);
      chk_halted("unhalt", 1'b0);
      flush = 1'b0;
      step();
      chk_pc("run_again_pc", 32'h84);
      chk_latch("run_again_latch", 32'h84, imem(32'h80), 1'b1);
   endtask

   task automatic test_enable();
      enable = 1'b0; flush = 1'b1; br_tgt = 32'h300;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_pc("en0_pc", 32'h84);
         chk_latch("en0_latch", 32'h84, imem(32'h80), 1'b1);
      end
      flush = 1'b0; pc_write = 1'b0; ifid_write = 1'b0;
      step();
      chk_cnt("en0_cnt_hold", EXP_STALLS);
      idle_inputs();
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_pc("async_rst_pc", 32'h0);
      chk_latch("async_rst_latch", 32'h0, 32'h0, 1'b0);
      chk_cnt("async_rst_cnt", 16'd0);
      #3;
      rst_n = 1'b1;
      step();
      chk_pc("post_rst_pc", 32'h4);
      chk_latch("post_rst_latch", 32'h4, imem(32'h0), 1'b1);
   endtask

   task automatic test_wrap();
      flush = 1'b1; br_tgt = 32'hFFFF_FFFC;
      step();
      chk_pc("wrap_setup_pc", 32'hFFFF_FFFC);
      flush = 1'b0;
      step();
      chk_pc("wrap_pc", 32'h0);
      chk_latch("wrap_latch", 32'h0, imem(32'hFFFF_FFFC), 1'b1);
   endtask

   initial begin
      test_reset();
      test_seq();
      test_stall();
      test_flush();
      test_redirect();
      test_halt();
      test_enable();
      test_async_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
